// File: rtl/fp_decoder_if.sv
// rtl/fp_decoder_if.sv - handshake bundle between a compressed-word producer/consumer and fp_decoder
interface fp_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic [11:0] D;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  modport master (
    output in_valid, S, E, F, out_ready,
    input  in_ready, D, out_valid, err
  );

  modport slave (
    input  in_valid, S, E, F, out_ready,
    output in_ready, D, out_valid, err
  );
endinterface

// File: rtl/fp_decoder.sv
// rtl/fp_decoder.sv - expands a sign/exponent/significand word into a 12-bit two's-complement value
module fp_decoder (
  input  logic          clk,
  input  logic          rst,
  fp_decoder_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        s_q, s_d;
  logic        e_nz_q, e_nz_d;
  logic        f3_q, f3_d;
  logic [11:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] d_q, d_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e_nz_d      = e_nz_q;
    f3_d        = f3_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.S;
          e_nz_d  = (bus.E != 3'd0);
          f3_d    = bus.F[3];
          mag_d   = {8'b0, bus.F};
          cnt_d   = bus.E;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 3'd0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        // Negation of a zero magnitude is zero, so negative zero needs no special case.
        d_d         = s_q ? (~mag_q + 12'd1) : mag_q;
        err_d       = e_nz_q && !f3_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_nz_q      <= 1'b0;
      f3_q        <= 1'b0;
      mag_q       <= 12'd0;
      cnt_q       <= 3'd0;
      d_q         <= 12'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_nz_q      <= e_nz_d;
      f3_q        <= f3_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // out_valid is only ever set in DONE, so it can never coincide with in_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fp_decoder.sv
// tb/tb_fp_decoder.sv - scoreboard bench for fp_decoder with directed vectors
module tb_fp_decoder;

  logic clk;
  logic rst;
  fp_decoder_if bus ();

  fp_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int err;
    int lat;
    int acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when out_valid first appears, then checks it holds.
  int  hold_d;
  int  hold_err;
  bit  seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else begin
      if (bus.out_valid && bus.in_ready) chk("valid_and_ready", 1, 0);
      if (bus.out_valid && !seen) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("D", int'(bus.D), e.d);
          chk("err", int'(bus.err), e.err);
          chk("latency", cyc + 1 - e.acc, e.lat);
        end
        hold_d   = int'(bus.D);
        hold_err = int'(bus.err);
        seen     = 1;
      end else if (bus.out_valid && seen) begin
        chk("hold_D", int'(bus.D), hold_d);
        chk("hold_err", int'(bus.err), hold_err);
      end
      if (!bus.out_valid) seen = 0;
    end
  end

  task automatic send(input bit s, input int e, input int f, input int exp_d, input int exp_err);
    int tmo;
    exp_t x;
    @(negedge clk);
    bus.S        = s;
    bus.E        = 3'(e);
    bus.F        = 4'(f);
    bus.in_valid = 1'b1;
    tmo = 0;
    while (!bus.in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) chk("accept_timeout", tmo, 0);
    x.d   = exp_d;
    x.err = exp_err;
    x.lat = e + 3;
    x.acc = cyc + 1;
    q.push_back(x);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble the word after the accept edge; the captured value must not change.
    bus.S = ~s;
    bus.E = ~3'(e);
    bus.F = ~4'(f);
  endtask

  task automatic wait_idle();
    int tmo;
    tmo = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.out_valid) && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) chk("idle_timeout", tmo, 0);
  endtask

  initial begin
    int tmo;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.S         = 1'b0;
    bus.E         = 3'd0;
    bus.F         = 4'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_D", int'(bus.D), 0);
    chk("rst_err", int'(bus.err), 0);

    send(0, 0, 0,  'h000, 0);
    send(0, 7, 15, 'h780, 0);
    send(1, 3, 10, 'hFB0, 0);
    send(1, 0, 0,  'h000, 0);
    send(0, 2, 5,  'h014, 1);
    send(1, 7, 8,  'hC00, 0);
    send(0, 1, 7,  'h00E, 1);
    send(1, 5, 15, 'hE20, 0);
    send(0, 0, 3,  'h003, 0);
    wait_idle();

    // Backpressure: hold for four cycles, with an ignored in_valid pulse in the middle.
    bus.out_ready = 1'b0;
    send(1, 2, 9, 'hFDC, 0);
    tmo = 0;
    while (!bus.out_valid && tmo < 30) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 30) chk("bp_valid_timeout", tmo, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      if (i == 1) begin
        bus.S = 1'b0; bus.E = 3'd4; bus.F = 4'd12;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    chk("bp_release_D", int'(bus.D), 'hFDC);
    wait_idle();

    // Reset mid-SHIFT with E=7 discards the word.
    send(0, 7, 15, 'h780, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_D", int'(bus.D), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_err", int'(bus.err), 0);
    repeat (15) @(negedge clk);

    // Reset wins over a simultaneous in_valid.
    bus.S = 1'b0; bus.E = 3'd1; bus.F = 4'd9;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_prio_in_ready", int'(bus.in_ready), 1);
    chk("rst_prio_out_valid", int'(bus.out_valid), 0);
    repeat (15) @(negedge clk);

    send(1, 4, 11, 'hF50, 0);
    wait_idle();
    chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
